// File: rtl/prbs_demodulator_if.sv
// Sample/config inputs and lock/BER status outputs of the PRBS demodulator.
// master = sample/config source, slave = demodulator.
interface prbs_demodulator_if;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [15:0] dc_offset_config;
    logic [15:0] samples_per_bit;
    logic [1:0]  prbs_sel;
    logic        clear_counts;
    logic        recovered_bit;
    logic        bit_strobe;
    logic        locked;
    logic        lock_lost;
    logic [31:0] bit_count;
    logic [31:0] err_count;

    modport master (
        output sample_in, sample_valid, dc_offset_config, samples_per_bit, prbs_sel, clear_counts,
        input  recovered_bit, bit_strobe, locked, lock_lost, bit_count, err_count
    );

    modport slave (
        input  sample_in, sample_valid, dc_offset_config, samples_per_bit, prbs_sel, clear_counts,
        output recovered_bit, bit_strobe, locked, lock_lost, bit_count, err_count
    );
endinterface

// File: rtl/prbs_demodulator.sv
// PRBS receive checker: slices samples, recovers bit timing from data edges,
// synchronises a local PRBS7/15/31 reference and counts bit errors while locked.
module prbs_demodulator #(
    parameter int LOCK_GOOD_BITS = 64,
    parameter int ERR_WINDOW     = 256,
    parameter int ERR_LIMIT      = 8
) (
    input  logic              dac_clk,
    input  logic              reset,
    prbs_demodulator_if.slave bus
);
    localparam int GW = $clog2(LOCK_GOOD_BITS + 1);
    localparam int WW = $clog2(ERR_WINDOW + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_GOOD_BITS - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(ERR_WINDOW - 1);
    localparam logic [EW-1:0] ERR_LIM   = EW'(ERR_LIMIT);

    typedef enum logic [1:0] {SEED, CHECK, LOCKED} state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [15:0] threshold;
    logic        sliced_q, sliced_d;
    logic        vld1_q, vld1_d;
    logic        prev_sliced_q, prev_sliced_d;
    logic [15:0] phase_q, phase_d;
    logic        bit_strobe_q, bit_strobe_d;
    logic        recovered_bit_q, recovered_bit_d;
    state_t      state_q, state_d;
    logic [30:0] lfsr_q, lfsr_d;
    logic [4:0]  seed_cnt_q, seed_cnt_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic [WW-1:0] win_cnt_q, win_cnt_d;
    logic [EW-1:0] win_err_q, win_err_d;
    logic [31:0] bit_count_q, bit_count_d;
    logic [31:0] err_count_q, err_count_d;
    logic        lock_lost_q, lock_lost_d;
    logic [1:0]  prbs_sel_q, prbs_sel_d;

    logic [4:0]    seed_last;
    logic [4:0]    tap_a;
    logic [4:0]    tap_b;
    logic          expected;
    logic          mismatch;
    logic          loss;
    logic [EW-1:0] win_err_inc;

    assign threshold = 16'h8000 + bus.dc_offset_config;

    // Stage 1: slicer
    always_comb begin
        sliced_d = sliced_q;
        vld1_d   = bus.sample_valid;
        if (bus.sample_valid) begin
            sliced_d = (bus.sample_in >= threshold);
        end
    end

    // Stage 2: edge-aligned phase counter and bit strobe
    always_comb begin
        prev_sliced_d   = prev_sliced_q;
        phase_d         = phase_q;
        bit_strobe_d    = 1'b0;
        recovered_bit_d = recovered_bit_q;
        if (vld1_q) begin
            prev_sliced_d = sliced_q;
            if (bus.samples_per_bit < 16'd2) begin
                phase_d         = 16'd0;
                bit_strobe_d    = 1'b1;
                recovered_bit_d = sliced_q;
            end else begin
                if (sliced_q != prev_sliced_q) begin
                    phase_d = 16'd0;
                end else if (phase_q >= bus.samples_per_bit - 16'd1) begin
                    // >= also recovers cleanly if samples_per_bit shrinks mid-count
                    phase_d = 16'd0;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
                if (phase_d == (bus.samples_per_bit >> 1)) begin
                    bit_strobe_d    = 1'b1;
                    recovered_bit_d = sliced_q;
                end
            end
        end
    end

    always_comb begin
        case (bus.prbs_sel)
            2'd0: begin seed_last = 5'd6;  tap_a = 5'd6;  tap_b = 5'd5;  end
            2'd1: begin seed_last = 5'd14; tap_a = 5'd14; tap_b = 5'd13; end
            default: begin seed_last = 5'd30; tap_a = 5'd30; tap_b = 5'd27; end
        endcase
        expected    = lfsr_q[tap_a] ^ lfsr_q[tap_b];
        mismatch    = recovered_bit_q ^ expected;
        win_err_inc = win_err_q + EW'(mismatch);
    end

    // Stage 3: reference LFSR, lock FSM and error counters
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        seed_cnt_d  = seed_cnt_q;
        good_cnt_d  = good_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        bit_count_d = bit_count_q;
        err_count_d = err_count_q;
        loss        = 1'b0;
        prbs_sel_d  = bus.prbs_sel;

        if (bus.prbs_sel != prbs_sel_q) begin
            state_d    = SEED;
            seed_cnt_d = 5'd0;
        end else if (bit_strobe_q) begin
            case (state_q)
                SEED: begin
                    lfsr_d = {lfsr_q[29:0], recovered_bit_q};
                    if (seed_cnt_q >= seed_last) begin
                        state_d    = CHECK;
                        seed_cnt_d = 5'd0;
                        good_cnt_d = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + 5'd1;
                    end
                end
                CHECK: begin
                    lfsr_d = {lfsr_q[29:0], recovered_bit_q};
                    if (mismatch) begin
                        state_d    = SEED;
                        seed_cnt_d = 5'd0;
                    end else if (good_cnt_q == GOOD_LAST) begin
                        state_d   = LOCKED;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + GW'(1);
                    end
                end
                LOCKED: begin
                    // Track the reference, not the line, so a single line error costs one count
                    lfsr_d      = {lfsr_q[29:0], expected};
                    bit_count_d = sat_inc(bit_count_q);
                    if (mismatch) begin
                        err_count_d = sat_inc(err_count_q);
                    end
                    if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WW'(1);
                        win_err_d = win_err_inc;
                    end
                    if (win_err_inc == ERR_LIM) begin
                        state_d    = SEED;
                        seed_cnt_d = 5'd0;
                        loss       = 1'b1;
                    end
                end
                default: begin
                    state_d    = SEED;
                    seed_cnt_d = 5'd0;
                end
            endcase
        end

        if (bus.clear_counts) begin
            bit_count_d = 32'd0;
            err_count_d = 32'd0;
        end
        lock_lost_d = (lock_lost_q & ~bus.clear_counts) | loss;
    end

    always_ff @(posedge dac_clk) begin
        if (reset) begin
            sliced_q        <= 1'b0;
            vld1_q          <= 1'b0;
            prev_sliced_q   <= 1'b0;
            phase_q         <= 16'd0;
            bit_strobe_q    <= 1'b0;
            recovered_bit_q <= 1'b0;
            state_q         <= SEED;
            lfsr_q          <= 31'd0;
            seed_cnt_q      <= 5'd0;
            good_cnt_q      <= '0;
            win_cnt_q       <= '0;
            win_err_q       <= '0;
            bit_count_q     <= 32'd0;
            err_count_q     <= 32'd0;
            lock_lost_q     <= 1'b0;
            prbs_sel_q      <= bus.prbs_sel;
        end else begin
            sliced_q        <= sliced_d;
            vld1_q          <= vld1_d;
            prev_sliced_q   <= prev_sliced_d;
            phase_q         <= phase_d;
            bit_strobe_q    <= bit_strobe_d;
            recovered_bit_q <= recovered_bit_d;
            state_q         <= state_d;
            lfsr_q          <= lfsr_d;
            seed_cnt_q      <= seed_cnt_d;
            good_cnt_q      <= good_cnt_d;
            win_cnt_q       <= win_cnt_d;
            win_err_q       <= win_err_d;
            bit_count_q     <= bit_count_d;
            err_count_q     <= err_count_d;
            lock_lost_q     <= lock_lost_d;
            prbs_sel_q      <= prbs_sel_d;
        end
    end

    assign bus.recovered_bit = recovered_bit_q;
    assign bus.bit_strobe    = bit_strobe_q;
    assign bus.locked        = (state_q == LOCKED);
    assign bus.lock_lost     = lock_lost_q;
    assign bus.bit_count     = bit_count_q;
    assign bus.err_count     = err_count_q;
endmodule

// File: tb/tb_prbs_demodulator.sv
// Directed bench for prbs_demodulator: a scoreboard queue of transmitted bits is
// checked against every bit_strobe, status outputs are checked at fixed points.
module tb_prbs_demodulator;
    logic dac_clk = 1'b0;
    logic reset;

    prbs_demodulator_if bus ();

    prbs_demodulator #(
        .LOCK_GOOD_BITS(64),
        .ERR_WINDOW(256),
        .ERR_LIMIT(8)
    ) dut (
        .dac_clk(dac_clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 dac_clk = ~dac_clk;

    int n_tests = 0;
    int n_fail = 0;
    int strobe_cnt = 0;
    logic [1:0] exp_q[$];        // {clear_on_this_strobe, expected_bit}
    logic [15:0] lvl_lo = 16'h4000;
    logic [15:0] lvl_hi = 16'hC000;
    int spb = 8;
    logic hist[0:63];
    int gn = 0;
    int g_n = 7;
    int g_t = 6;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor; also raises clear_counts in a flagged strobe cycle.
    initial begin
        logic [1:0] e;
        bus.clear_counts = 1'b0;
        forever begin
            @(negedge dac_clk);
            bus.clear_counts = 1'b0;
            if (bus.bit_strobe === 1'b1) begin
                strobe_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("recovered_bit", 32'(bus.recovered_bit), 32'(e[0]));
                    if (e[1]) bus.clear_counts = 1'b1;
                end
            end
        end
    end

    // Reference stream from the recurrence b[n] = b[n-N] ^ b[n-T], seeded with N ones.
    task automatic gen_start(input int n, input int t);
        g_n = n;
        g_t = t;
        gn  = 0;
    endtask

    task automatic gen_next(output logic b);
        if (gn < g_n) b = 1'b1;
        else b = hist[(gn - g_n) % 64] ^ hist[(gn - g_t) % 64];
        hist[gn % 64] = b;
        gn++;
    endtask

    task automatic send_bit(input logic b, input logic clr);
        exp_q.push_back({clr, b});
        for (int i = 0; i < spb; i++) begin
            @(negedge dac_clk);
            bus.sample_valid = 1'b1;
            bus.sample_in    = b ? lvl_hi : lvl_lo;
        end
    endtask

    task automatic send_prbs(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen_next(b);
            send_bit(b, 1'b0);
        end
    endtask

    task automatic send_raw(input logic [15:0] s, input logic b);
        exp_q.push_back({1'b0, b});
        @(negedge dac_clk);
        bus.sample_valid = 1'b1;
        bus.sample_in    = s;
    endtask

    task automatic idle(input int n);
        @(negedge dac_clk);
        bus.sample_valid = 1'b0;
        repeat (n - 1) @(negedge dac_clk);
    endtask

    task automatic do_reset();
        @(negedge dac_clk);
        reset = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_in    = lvl_hi;
        @(negedge dac_clk);
        reset = 1'b0;
        bus.sample_valid = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic b;
        reset                = 1'b1;
        bus.sample_in        = 16'h0000;
        bus.sample_valid     = 1'b0;
        bus.dc_offset_config = 16'h0000;
        bus.samples_per_bit  = 16'd8;
        bus.prbs_sel         = 2'd0;
        repeat (3) @(negedge dac_clk);
        reset = 1'b0;
        @(negedge dac_clk);

        check("rst_recovered_bit", 32'(bus.recovered_bit), 32'd0);
        check("rst_bit_strobe", 32'(bus.bit_strobe), 32'd0);
        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_lock_lost", 32'(bus.lock_lost), 32'd0);
        check("rst_bit_count", bus.bit_count, 32'd0);
        check("rst_err_count", bus.err_count, 32'd0);

        for (int i = 0; i < 100; i++) begin
            @(negedge dac_clk);
            bus.sample_in = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
        end
        check("idle_strobes", 32'(strobe_cnt), 32'd0);
        check("idle_locked", 32'(bus.locked), 32'd0);

        // PRBS7 clean lock and 1000 counted bits
        gen_start(7, 6);
        send_prbs(70);
        idle(4);
        check("p7_locked_early", 32'(bus.locked), 32'd0);
        send_prbs(1);
        idle(4);
        check("p7_locked", 32'(bus.locked), 32'd1);
        send_prbs(1000);
        idle(4);
        check("p7_bit_count", bus.bit_count, 32'd1000);
        check("p7_err_count", bus.err_count, 32'd0);
        check("p7_lock_lost", 32'(bus.lock_lost), 32'd0);

        bus.prbs_sel = 2'd1;
        @(negedge dac_clk);
        check("sel_chg_locked", 32'(bus.locked), 32'd0);
        check("sel_chg_bit_count", bus.bit_count, 32'd1000);
        check("sel_chg_err_count", bus.err_count, 32'd0);

        // PRBS15 single error, then clear coincident with an error strobe
        do_reset();
        gen_start(15, 14);
        send_prbs(79);
        idle(4);
        check("p15_locked", 32'(bus.locked), 32'd1);
        send_prbs(20);
        gen_next(b);
        send_bit(~b, 1'b0);
        send_prbs(20);
        idle(4);
        check("p15_err_count", bus.err_count, 32'd1);
        check("p15_bit_count", bus.bit_count, 32'd41);
        check("p15_locked_kept", 32'(bus.locked), 32'd1);
        check("p15_lock_lost", 32'(bus.lock_lost), 32'd0);
        send_prbs(10);
        gen_next(b);
        send_bit(~b, 1'b1);
        idle(4);
        check("clr_err_count", bus.err_count, 32'd0);
        check("clr_bit_count", bus.bit_count, 32'd0);
        check("clr_locked", 32'(bus.locked), 32'd1);
        send_prbs(10);
        idle(4);
        check("post_clr_bit_count", bus.bit_count, 32'd10);

        // Reset while locked, then PRBS31 loss of lock and relock
        bus.prbs_sel = 2'd2;
        do_reset();
        check("midrst_locked", 32'(bus.locked), 32'd0);
        check("midrst_bit_count", bus.bit_count, 32'd0);
        check("midrst_strobe", 32'(bus.bit_strobe), 32'd0);
        gen_start(31, 28);
        send_prbs(94);
        idle(4);
        check("p31_locked_early", 32'(bus.locked), 32'd0);
        send_prbs(1);
        idle(4);
        check("p31_locked", 32'(bus.locked), 32'd1);
        for (int k = 0; k < 80; k++) begin
            gen_next(b);
            send_bit((k % 10 == 5) ? ~b : b, 1'b0);
        end
        idle(4);
        check("loss_locked", 32'(bus.locked), 32'd0);
        check("loss_lock_lost", 32'(bus.lock_lost), 32'd1);
        check("loss_err_count", bus.err_count, 32'd8);
        check("loss_bit_count", bus.bit_count, 32'd76);
        send_prbs(90);
        idle(4);
        check("relock_early", 32'(bus.locked), 32'd0);
        send_prbs(1);
        idle(4);
        check("relock_locked", 32'(bus.locked), 32'd1);
        check("relock_err_count", bus.err_count, 32'd8);
        gen_next(b);
        send_bit(b, 1'b1);
        idle(4);
        check("clr_lock_lost", 32'(bus.lock_lost), 32'd0);
        check("clr2_err_count", bus.err_count, 32'd0);

        // Slicer threshold: one bit per sample
        do_reset();
        bus.samples_per_bit  = 16'd1;
        spb                  = 1;
        bus.dc_offset_config = 16'h2000;
        send_raw(16'h9000, 1'b0);
        send_raw(16'h9800, 1'b0);
        send_raw(16'hA000, 1'b1);
        send_raw(16'h9FFF, 1'b0);
        send_raw(16'hB000, 1'b1);
        send_raw(16'h9000, 1'b0);
        send_raw(16'hFFFF, 1'b1);
        bus.dc_offset_config = 16'h9000;
        send_raw(16'h0FFF, 1'b0);
        send_raw(16'h1000, 1'b1);
        idle(6);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
